// File: rtl/alu_responder_pkg.sv
// Shared types and constants for the ALU responder.
// Build option: ALU_RESPONDER_MUL_EN enables the 0xB1 multiply opcode.
package alu_responder_pkg;

  localparam int HDR_BYTES     = 4;
  localparam int OPERAND_BYTES = 4;

`ifdef ALU_RESPONDER_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hA1,
    OP_MUL  = 8'hB1
  } op_e;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_DRAIN,
    S_RESP
  } state_e;

  // True for opcodes that accumulate operands and return a 32-bit result.
  function automatic logic op_is_alu(input logic [7:0] op);
    return (op == OP_ADD) || (MUL_EN && (op == OP_MUL));
  endfunction

endpackage

// File: rtl/alu_responder_exec.sv
// Combinational accumulator update: folds one 32-bit operand into the
// running accumulator. The multiplier exists only when ALU_RESPONDER_MUL_EN
// is defined.
module alu_responder_exec
  import alu_responder_pkg::*;
(
  input  op_e         op_i,
  input  logic [31:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [31:0] acc_o
);

  // Select the arithmetic for the current opcode; other codes hold acc.
  always_comb begin
    // NOTE: default assignment first so every path drives acc_o (no latch).
    acc_o = acc_i;
    case (op_i)
      OP_ADD: acc_o = acc_i + operand_i;
`ifdef ALU_RESPONDER_MUL_EN
      OP_MUL: acc_o = acc_i * operand_i;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_responder.sv
// Packet-level ALU responder between UART rx and tx AXI-Stream ports.
// Parses {opcode, reserved, len_lo, len_hi, payload} frames and answers
// with echoed payload or a 32-bit little-endian add/mul result.
// Build option: ALU_RESPONDER_MUL_EN enables opcode 0xB1 (multiply).
module alu_responder
  import alu_responder_pkg::*;
#(
  parameter int datawidth_p    = 8,
  parameter int idle_timeout_p = 1000000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [datawidth_p-1:0] tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic                   error_o
);

  if (datawidth_p != 8) begin : g_width_check
    $error("alu_responder: datawidth_p must be 8");
  end

  localparam logic [31:0] TMO_LAST = 32'(idle_timeout_p) - 32'd1;

  state_e      state_q;
  logic [7:0]  opcode_q;
  logic [7:0]  len_lo_q;
  logic [15:0] rem_q;
  logic [31:0] acc_q;
  logic [23:0] operand_q;
  logic [1:0]  byte_idx_q;
  logic [1:0]  resp_idx_q;
  logic [31:0] tmo_q;
  logic        error_q;

  logic        is_echo;
  logic        in_frame;
  logic        rx_hs;
  logic        tmo_hit;
  logic [15:0] len_w;
  logic [15:0] pay_w;
  logic [31:0] acc_next;

  assign is_echo  = (opcode_q == OP_ECHO);
  assign in_frame = state_q inside {S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_DRAIN};
  assign rx_hs    = rx_valid_i & rx_ready_o;
  assign tmo_hit  = (idle_timeout_p != 0) && in_frame && !rx_valid_i && (tmo_q == TMO_LAST);
  assign len_w    = {rx_data_i[7:0], len_lo_q};
  assign pay_w    = len_w - 16'(HDR_BYTES);
  assign busy_o   = (state_q != S_OPCODE);
  assign error_o  = error_q;

  alu_responder_exec u_exec (
    .op_i      (op_e'(opcode_q)),
    .acc_i     (acc_q),
    .operand_i ({rx_data_i[7:0], operand_q}),
    .acc_o     (acc_next)
  );

  // Stream handshakes: echo payload is a combinational pass-through,
  // responses come from the accumulator, everything else just accepts rx.
  always_comb begin
    rx_ready_o = 1'b1;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    case (state_q)
      S_PAYLOAD: begin
        if (is_echo) begin
          rx_ready_o = tx_ready_i;
          tx_valid_o = rx_valid_i;
          tx_data_o  = rx_data_i;
        end
      end
      S_RESP: begin
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b1;
        tx_data_o  = acc_q[{resp_idx_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  // Frame parser FSM with byte counters, accumulator and idle timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_OPCODE;
      opcode_q   <= '0;
      len_lo_q   <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      operand_q  <= '0;
      byte_idx_q <= '0;
      resp_idx_q <= '0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      error_q <= 1'b0;
      if ((idle_timeout_p != 0) && in_frame && !rx_valid_i) tmo_q <= tmo_q + 32'd1;
      else                                                   tmo_q <= '0;

      if (tmo_hit) begin
        state_q <= S_OPCODE;
        error_q <= 1'b1;
        acc_q   <= '0;
        rem_q   <= '0;
        tmo_q   <= '0;
      end else begin
        case (state_q)
          S_OPCODE: if (rx_hs) begin
            opcode_q <= rx_data_i[7:0];
            state_q  <= S_RSVD;
          end
          S_RSVD: if (rx_hs) state_q <= S_LEN_LO;
          S_LEN_LO: if (rx_hs) begin
            len_lo_q <= rx_data_i[7:0];
            state_q  <= S_LEN_HI;
          end
          S_LEN_HI: if (rx_hs) begin
            rem_q      <= pay_w;
            byte_idx_q <= '0;
            if (len_w < 16'(HDR_BYTES)) begin
              error_q <= 1'b1;
              state_q <= S_OPCODE;
            end else if (is_echo) begin
              state_q <= (pay_w == '0) ? S_OPCODE : S_PAYLOAD;
            end else if (op_is_alu(opcode_q) && (pay_w != '0) &&
                         ((pay_w % 16'(OPERAND_BYTES)) == '0)) begin
              acc_q   <= (opcode_q == OP_ADD) ? 32'd0 : 32'd1;
              state_q <= S_PAYLOAD;
            end else begin
              // Unknown opcode or bad operand length: flag and skip the payload.
              error_q <= 1'b1;
              state_q <= (pay_w == '0) ? S_OPCODE : S_DRAIN;
            end
          end
          S_PAYLOAD: if (rx_hs) begin
            rem_q <= rem_q - 16'd1;
            if (is_echo) begin
              if (rem_q == 16'd1) state_q <= S_OPCODE;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              case (byte_idx_q)
                2'd0:    operand_q[7:0]   <= rx_data_i[7:0];
                2'd1:    operand_q[15:8]  <= rx_data_i[7:0];
                2'd2:    operand_q[23:16] <= rx_data_i[7:0];
                default: acc_q            <= acc_next;
              endcase
              if (rem_q == 16'd1) begin
                resp_idx_q <= '0;
                state_q    <= S_RESP;
              end
            end
          end
          S_DRAIN: if (rx_hs) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) state_q <= S_OPCODE;
          end
          S_RESP: if (tx_ready_i) begin
            resp_idx_q <= resp_idx_q + 2'd1;
            if (resp_idx_q == 2'd3) state_q <= S_OPCODE;
          end
          default: state_q <= S_OPCODE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: table of frames with expected
// response bytes and error pulse counts, a scoreboard queue popped by a
// tx monitor, plus hand-written timeout and mid-response reset sequences.
module tb_alu_responder;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       error_o;

  logic tx_tog;
  logic tx_rdy_man;
  logic tog_phase = 1'b0;

  assign tx_ready_i = tx_tog ? tog_phase : tx_rdy_man;

  always #5 clk = ~clk;
  always @(negedge clk) tog_phase <= ~tog_phase;

  alu_responder #(.datawidth_p(8), .idle_timeout_p(TMO)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .error_o    (error_o)
  );

  typedef struct packed {
    logic [127:0] frame;  // right-aligned, first byte leftmost
    logic [4:0]   n;
    logic [31:0]  tx;     // right-aligned, first byte leftmost
    logic [2:0]   tx_n;
    logic [1:0]   err;
    logic         tog;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         err_total = 0;
  logic [7:0] sb [$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // tx monitor: compares each transferred byte against the scoreboard,
  // checks hold-under-backpressure and counts error_o high cycles.
  always @(negedge clk) begin
    #1;
    if (!rst_ni) begin
      stall_q = 1'b0;
    end else begin
      if (error_o) err_total++;
      if (stall_q) check("tx_hold", {55'd0, tx_valid_o, tx_data_o}, {55'd0, 1'b1, stall_data});
      if (tx_valid_o && tx_ready_i) begin
        if (sb.size() == 0) check("tx_unexpected", {56'd0, tx_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        else                check("tx_byte", {56'd0, tx_data_o}, {56'd0, sb.pop_front()});
      end
      stall_q    = tx_valid_o && !tx_ready_i;
      stall_data = tx_data_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic hs;
    logic done;
    done = 1'b0;
    @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    #1;
    for (int k = 0; k < 100; k++) begin
      hs = rx_ready_o;
      @(posedge clk);
      if (hs) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!done) check("rx_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #2;
      if (!busy_o && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int base;
    base = err_total;
    for (int i = 0; i < int'(v.tx_n); i++) sb.push_back(v.tx[(int'(v.tx_n) - 1 - i) * 8 +: 8]);
    tx_tog = v.tog;
    for (int i = 0; i < int'(v.n); i++) send_byte(v.frame[(int'(v.n) - 1 - i) * 8 +: 8]);
    @(negedge clk);
    rx_valid_i = 1'b0;
    wait_idle();
    tx_tog = 1'b0;
    check($sformatf("vec%0d_err", idx), 64'(err_total - base), {62'd0, v.err});
    check($sformatf("vec%0d_tx_left", idx), 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base;
    rst_ni     = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    tx_rdy_man = 1'b1;
    tx_tog     = 1'b0;

    vecs[0] = '{frame: 128'(96'hA1000C00_01000000_FFFFFFFF), n: 5'd12, tx: 32'h00000000, tx_n: 3'd4, err: 2'd0, tog: 1'b0};
`ifdef ALU_RESPONDER_MUL_EN
    vecs[1] = '{frame: 128'(96'hB1000C00_03000000_05000000), n: 5'd12, tx: 32'h0F000000, tx_n: 3'd4, err: 2'd0, tog: 1'b0};
`else
    vecs[1] = '{frame: 128'(96'hB1000C00_03000000_05000000), n: 5'd12, tx: 32'h0, tx_n: 3'd0, err: 2'd1, tog: 1'b0};
`endif
    vecs[2] = '{frame: 128'(56'hEC000700_414243), n: 5'd7, tx: 32'h00414243, tx_n: 3'd3, err: 2'd0, tog: 1'b1};
    vecs[3] = '{frame: 128'(48'h55000600_AABB), n: 5'd6, tx: 32'h0, tx_n: 3'd0, err: 2'd1, tog: 1'b0};
    vecs[4] = '{frame: 128'(64'hA1000800_07000000), n: 5'd8, tx: 32'h07000000, tx_n: 3'd4, err: 2'd0, tog: 1'b0};
    vecs[5] = '{frame: 128'(32'hA1000300), n: 5'd4, tx: 32'h0, tx_n: 3'd0, err: 2'd1, tog: 1'b0};
    vecs[6] = '{frame: 128'(32'hEC000400), n: 5'd4, tx: 32'h0, tx_n: 3'd0, err: 2'd0, tog: 1'b0};
    vecs[7] = '{frame: 128'(48'hA1000600_1122), n: 5'd6, tx: 32'h0, tx_n: 3'd0, err: 2'd1, tog: 1'b0};
    vecs[8] = '{frame: 128'(32'hA1000400), n: 5'd4, tx: 32'h0, tx_n: 3'd0, err: 2'd1, tog: 1'b0};
    vecs[9] = '{frame: 128'hA1001000_10000000_20000000_30000000, n: 5'd16, tx: 32'h60000000, tx_n: 3'd4, err: 2'd0, tog: 1'b1};

    #1;
    check("reset_outputs", {59'd0, rx_ready_o, tx_valid_o, busy_o, error_o, |tx_data_o},
          {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    for (int v = 0; v < NV; v++) run_vec(v, vecs[v]);

    // Idle timeout mid-frame, then a normal frame.
    base = err_total;
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    @(negedge clk);
    rx_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check("tmo_not_early", {63'd0, busy_o}, 64'd1);
    wait_idle();
    check("tmo_err", 64'(err_total - base), 64'd1);
    check("tmo_tx_left", 64'(sb.size()), 64'd0);
    run_vec(104, vecs[4]);

    // Reset during the second result byte of an add response.
    base = err_total;
    sb.push_back(8'h05);
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    #1;
    rx_valid_i = 1'b0;
    check("resp_latency", {55'd0, tx_valid_o, tx_data_o}, {55'd0, 1'b1, 8'h05});
    @(posedge clk);
    #1;
    check("resp_byte1", {55'd0, tx_valid_o, tx_data_o}, {55'd0, 1'b1, 8'h00});
    tx_rdy_man = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("reset_mid_resp", {60'd0, tx_valid_o, busy_o, rx_ready_o, |tx_data_o},
          {60'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_ni     = 1'b1;
    tx_rdy_man = 1'b1;
    check("reset_tx_left", 64'(sb.size()), 64'd0);
    check("reset_err", 64'(err_total - base), 64'd0);
    run_vec(100, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
